// File: rtl/fexp2_unit_pkg.sv
// Shared bfloat16 field widths, FSM state encoding and special result encodings
// for the exp2 datapath.
package fexp2_unit_pkg;
    localparam int EXP_WIDTH   = 8;
    localparam int FRACT_WIDTH = 7;
    localparam int S_WIDTH     = 1;
    localparam int BF_WIDTH    = S_WIDTH + EXP_WIDTH + FRACT_WIDTH;
    localparam int BIAS        = 127;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        EVAL  = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } fexp_state_t;

    localparam logic [BF_WIDTH-1:0] BF_QNAN  = 16'h7FC0;
    localparam logic [BF_WIDTH-1:0] BF_PINF  = 16'h7F80;
    localparam logic [BF_WIDTH-1:0] BF_PZERO = 16'h0000;
    localparam logic [BF_WIDTH-1:0] BF_ONE   = 16'h3F80;
endpackage

// File: rtl/fexp2_unit_if.sv
// Operand/result bundle of the exp2 unit plus its FSM state for observation.
interface fexp2_unit_if
    import fexp2_unit_pkg::*;
();
    logic [S_WIDTH-1:0]     sign;
    logic [EXP_WIDTH-1:0]   exponent;
    logic [FRACT_WIDTH-1:0] fractional;
    logic                   valid_i;
    logic [S_WIDTH-1:0]     s_res_o;
    logic [EXP_WIDTH-1:0]   e_res_o;
    logic [FRACT_WIDTH-1:0] f_res_o;
    logic                   valid_o;
    logic                   busy_o;
    fexp_state_t            state;

    modport master (
        output sign, exponent, fractional, valid_i,
        input  s_res_o, e_res_o, f_res_o, valid_o, busy_o, state
    );
    modport slave (
        input  sign, exponent, fractional, valid_i,
        output s_res_o, e_res_o, f_res_o, valid_o, busy_o, state
    );
endinterface

// File: rtl/fexp2_const_rom.sv
// Table of C_k = 2^(2^-(idx+1)) in Q1.ACC_W, built by repeated square roots of 2
// while the design is elaborated.
module fexp2_const_rom #(
    parameter int FXP_FRAC = 16,
    parameter int ACC_W    = 22
) (
    input  logic [$clog2(FXP_FRAC)-1:0] k_idx,
    output logic [ACC_W:0]              c_k
);
    function automatic logic [FXP_FRAC-1:0][ACC_W:0] build_table();
        logic [FXP_FRAC-1:0][ACC_W:0] t;
        real c;
        real s;
        c = 2.0;
        for (int k = 0; k < FXP_FRAC; k++) begin
            s = c;
            for (int i = 0; i < 60; i++) s = 0.5 * (s + c / s);
            c = s;
            t[k] = (ACC_W+1)'($rtoi(c * real'(1 << ACC_W) + 0.5));
        end
        return t;
    endfunction

    localparam logic [FXP_FRAC-1:0][ACC_W:0] C_TABLE = build_table();

    assign c_k = C_TABLE[k_idx];
endmodule

// File: rtl/fexp2_unit.sv
// bfloat16 y = 2^x: x is aligned to Q8.FXP_FRAC, 2^frac is built one fraction bit per
// cycle from a constant table, then rounded to nearest-even with floor(x) as exponent.
module fexp2_unit
    import fexp2_unit_pkg::*;
#(
    parameter int FXP_FRAC = 16,
    parameter int ACC_W    = 22
) (
    input  logic        clk,
    input  logic        rst,
    fexp2_unit_if.slave bus
);
    localparam int INT_W  = 8;
    localparam int X_W    = INT_W + FXP_FRAC;
    localparam int CNT_W  = $clog2(FXP_FRAC);
    localparam int MANT_W = FRACT_WIDTH + 1;
    localparam int UNB_W  = EXP_WIDTH + 2;
    localparam logic signed [UNB_W-1:0] BIAS_S = UNB_W'(BIAS);
    localparam logic signed [UNB_W-1:0] SH_MAX = UNB_W'(INT_W - 1);
    localparam logic signed [UNB_W-1:0] E_MAX  = UNB_W'(2**EXP_WIDTH - 1);
    localparam logic [ACC_W:0]          ACC_ONE = {1'b1, {ACC_W{1'b0}}};

    fexp_state_t            state_q, state_d;
    logic [S_WIDTH-1:0]     op_sign_q;
    logic [EXP_WIDTH-1:0]   op_exp_q;
    logic [FRACT_WIDTH-1:0] op_frac_q;
    logic [INT_W-1:0]       n_q;
    logic [FXP_FRAC-1:0]    r_q;
    logic [ACC_W:0]         acc_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   special_q;
    logic [BF_WIDTH-1:0]    special_val_q;
    logic [S_WIDTH-1:0]     s_res_q;
    logic [EXP_WIDTH-1:0]   e_res_q;
    logic [FRACT_WIDTH-1:0] f_res_q;
    logic                   valid_q, valid_d, busy_q;

    logic signed [UNB_W-1:0] unb;
    logic [UNB_W-1:0]        sh_r;
    logic [X_W-1:0]          mant_fx, mag, x_fx;
    logic                    is_special;
    logic [BF_WIDTH-1:0]     special_val;

    assign unb  = $signed({2'b00, op_exp_q}) - BIAS_S;
    assign sh_r = -unb;

    always_comb begin
        mant_fx = X_W'({1'b1, op_frac_q}) << (FXP_FRAC - FRACT_WIDTH);
        mag     = unb[UNB_W-1] ? (mant_fx >> sh_r) : (mant_fx << $unsigned(unb));
        x_fx    = op_sign_q[0] ? (~mag + 1'b1) : mag;
    end

    always_comb begin
        is_special  = 1'b1;
        special_val = BF_PZERO;
        if (op_exp_q == '1)
            special_val = (op_frac_q != '0) ? BF_QNAN : (op_sign_q[0] ? BF_PZERO : BF_PINF);
        else if (op_exp_q == '0)
            special_val = BF_ONE;
        else if (unb >= SH_MAX)
            special_val = op_sign_q[0] ? BF_PZERO : BF_PINF;
        else
            is_special = 1'b0;
    end

    logic [ACC_W:0]       c_k;
    logic [2*ACC_W+1:0]   prod;
    logic                 prod_unused;

    fexp2_const_rom #(.FXP_FRAC(FXP_FRAC), .ACC_W(ACC_W)) u_rom (
        .k_idx (cnt_q),
        .c_k   (c_k)
    );

    assign prod        = acc_q * c_k;
    assign prod_unused = ^{prod[2*ACC_W+1], prod[ACC_W-1:0]};

    logic                    lsb, guard, sticky, rnd_up;
    logic [MANT_W:0]         mant_r;
    logic signed [UNB_W-1:0] e_calc;
    logic [BF_WIDTH-1:0]     norm_val, result;

    always_comb begin
        lsb    = acc_q[ACC_W-FRACT_WIDTH];
        guard  = acc_q[ACC_W-FRACT_WIDTH-1];
        sticky = |acc_q[ACC_W-FRACT_WIDTH-2:0];
        rnd_up = guard & (sticky | lsb);
        mant_r = {1'b0, acc_q[ACC_W -: MANT_W]} + {{MANT_W{1'b0}}, rnd_up};
        // A carry out of the rounded mantissa means 2.0: bump E, low fraction bits are already 0
        e_calc = $signed({{(UNB_W-INT_W){n_q[INT_W-1]}}, n_q}) + BIAS_S
               + $signed({{(UNB_W-1){1'b0}}, mant_r[MANT_W]});
        if (e_calc[UNB_W-1] || (e_calc == '0))
            norm_val = BF_PZERO;
        else if (e_calc >= E_MAX)
            norm_val = BF_PINF;
        else
            norm_val = {{S_WIDTH{1'b0}}, e_calc[EXP_WIDTH-1:0], mant_r[FRACT_WIDTH-1:0]};
        result = special_q ? special_val_q : norm_val;
    end

    // Handshake: valid_i is sampled only in IDLE and must stay high until valid_o is seen;
    // valid_o rises one edge after DONE is entered and drops on the first edge in DONE
    // (with valid_o already high) where valid_i is low, returning to IDLE without re-accepting.
    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE:  if (bus.valid_i) state_d = ALIGN;
            ALIGN: state_d = EVAL;
            EVAL:  if (cnt_q == CNT_W'(FXP_FRAC - 1)) state_d = NORM;
            NORM:  state_d = DONE;
            DONE: begin
                if (valid_q && !bus.valid_i) state_d = IDLE;
                else                         valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            op_sign_q     <= '0;
            op_exp_q      <= '0;
            op_frac_q     <= '0;
            n_q           <= '0;
            r_q           <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            s_res_q       <= '0;
            e_res_q       <= '0;
            f_res_q       <= '0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            busy_q  <= (state_d != IDLE);
            unique case (state_q)
                IDLE: if (bus.valid_i) begin
                    op_sign_q <= bus.sign;
                    op_exp_q  <= bus.exponent;
                    op_frac_q <= bus.fractional;
                end
                ALIGN: begin
                    n_q           <= x_fx[X_W-1 -: INT_W];
                    r_q           <= x_fx[FXP_FRAC-1:0];
                    special_q     <= is_special;
                    special_val_q <= special_val;
                    acc_q         <= ACC_ONE;
                    cnt_q         <= '0;
                end
                EVAL: begin
                    if (r_q[FXP_FRAC-1]) acc_q <= prod[2*ACC_W:ACC_W];
                    r_q   <= r_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                end
                NORM: {s_res_q, e_res_q, f_res_q} <= result;
                default: ;
            endcase
        end
    end

    assign bus.s_res_o = s_res_q;
    assign bus.e_res_o = e_res_q;
    assign bus.f_res_o = f_res_q;
    assign bus.valid_o = valid_q;
    assign bus.busy_o  = busy_q;
    assign bus.state   = state_q;
endmodule
